// File: rtl/brisc_pkg.sv
// Shared writeback types and defaults for the brisc core.
// Holds write-source / arbiter-state enums and the MUL FIFO entry struct.
package brisc_pkg;

  localparam int XLEN            = 32;
  localparam int REG_BITS        = 5;
  localparam int MUL_FIFO_DEPTH  = 4;
  localparam int WB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MUL  = 2'd2
  } wb_src_e;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_arb_state_e;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     res;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/MUL requests, readies, and the register-file
// write port. master = pipeline side, slave = arbiter side.
interface wb_arbiter_if #(
  parameter int MUL_FIFO_DEPTH = brisc_pkg::MUL_FIFO_DEPTH
);
  import brisc_pkg::*;
  localparam int CW = $clog2(MUL_FIFO_DEPTH + 1);

  logic                flush_in;
  logic                alu_valid_in;
  logic [REG_BITS-1:0] alu_rd_in;
  logic [XLEN-1:0]     alu_res_in;
  logic                alu_ready_out;
  logic                mul_valid_in;
  logic [REG_BITS-1:0] mul_rd_in;
  logic [XLEN-1:0]     mul_res_in;
  logic                mul_ready_out;
  logic                reg_write_out;
  logic [REG_BITS-1:0] rd_write_out;
  logic [XLEN-1:0]     result_out;
  wb_src_e             wb_src_out;
  logic [CW-1:0]       mul_pending_out;

  modport master (
    output flush_in,
    output alu_valid_in, alu_rd_in, alu_res_in,
    output mul_valid_in, mul_rd_in, mul_res_in,
    input  alu_ready_out, mul_ready_out,
    input  reg_write_out, rd_write_out, result_out,
    input  wb_src_out, mul_pending_out
  );

  modport slave (
    input  flush_in,
    input  alu_valid_in, alu_rd_in, alu_res_in,
    input  mul_valid_in, mul_rd_in, mul_res_in,
    output alu_ready_out, mul_ready_out,
    output reg_write_out, rd_write_out, result_out,
    output wb_src_out, mul_pending_out
  );

endinterface

// File: rtl/wb_mul_fifo.sv
// Circular buffer of pending MUL writebacks {rd, res}.
// Ports: clk_i, rst_ni, push_i, pop_i, data_i -> data_o, full_o, empty_o, count_o.
module wb_mul_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? inc(wr_q) : wr_q;
    rd_d  = do_pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one register-file write per cycle from ALU, MUL FIFO or MUL bypass.
// Ports: clk, reset_n, bus (wb_arbiter_if.slave). Option: WB_ARB_FAIR_EN (starvation grant).
module wb_arbiter #(
  parameter int MUL_FIFO_DEPTH  = brisc_pkg::MUL_FIFO_DEPTH,
  parameter int WB_STARVE_LIMIT = brisc_pkg::WB_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_arbiter_if.slave bus
);
  import brisc_pkg::*;
  localparam int CW = $clog2(MUL_FIFO_DEPTH + 1);

  wb_arb_state_e       state_q, state_d;
  wb_req_t             head, mul_in;
  logic [CW-1:0]       cnt;
  logic                fifo_full, fifo_empty;
  logic                alu_req, mul_ready, mul_acc, push;
  logic                forced, g_alu, g_fifo, g_byp;
  logic                wr_q, wr_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic [XLEN-1:0]     res_q, res_d;
  wb_src_e             src_q, src_d;

  assign alu_req   = bus.alu_valid_in && !bus.flush_in;
  assign mul_ready = reset_n && !fifo_full;
  assign mul_acc   = bus.mul_valid_in && mul_ready;
  assign mul_in    = {bus.mul_rd_in, bus.mul_res_in};
  assign push      = mul_acc && !g_byp;

  wb_mul_fifo #(
    .DEPTH (MUL_FIFO_DEPTH),
    .W     ($bits(wb_req_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (g_fifo),
    .data_i  (mul_in),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cnt)
  );

`ifdef WB_ARB_FAIR_EN
  localparam int SW = $clog2(WB_STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = !fifo_empty && (starve_q == SW'(WB_STARVE_LIMIT));

  // Counts only cycles where a queued MUL result lost arbitration.
  always_comb begin
    starve_d = '0;
    if (!fifo_empty && !g_fifo)
      starve_d = starved ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  logic starved;
  logic unused_limit;
  assign starved      = 1'b0;
  assign unused_limit = (WB_STARVE_LIMIT > 0);
`endif

  always_comb begin
    state_d = state_q;
    forced  = 1'b0;
    g_alu   = 1'b0;
    g_fifo  = 1'b0;
    g_byp   = 1'b0;
    unique case (state_q)
      NORMAL: begin
        forced = starved;
        // Bypass only with an empty FIFO keeps MUL results in order.
        if (forced)           g_fifo = 1'b1;
        else if (alu_req)     g_alu  = 1'b1;
        else if (!fifo_empty) g_fifo = 1'b1;
        else if (mul_acc)     g_byp  = 1'b1;
        if (fifo_full) state_d = DRAIN;
      end
      DRAIN: begin
        g_fifo = !fifo_empty;
        if (fifo_empty || (cnt == CW'(1) && !mul_acc))
          state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign bus.alu_ready_out = reset_n &&
    (bus.flush_in || (state_q == NORMAL && !forced));
  assign bus.mul_ready_out = mul_ready;

  always_comb begin
    wr_d  = 1'b0;
    rd_d  = '0;
    res_d = '0;
    src_d = WB_SRC_NONE;
    unique case (1'b1)
      g_alu: begin
        wr_d  = (bus.alu_rd_in != '0);
        rd_d  = bus.alu_rd_in;
        res_d = bus.alu_res_in;
        src_d = WB_SRC_ALU;
      end
      g_fifo: begin
        wr_d  = (head.rd != '0);
        rd_d  = head.rd;
        res_d = head.res;
        src_d = WB_SRC_MUL;
      end
      g_byp: begin
        wr_d  = (mul_in.rd != '0);
        rd_d  = mul_in.rd;
        res_d = mul_in.res;
        src_d = WB_SRC_MUL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NORMAL;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      src_q   <= WB_SRC_NONE;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      src_q   <= src_d;
    end
  end

  assign bus.reg_write_out   = wr_q;
  assign bus.rd_write_out    = rd_q;
  assign bus.result_out      = res_q;
  assign bus.wb_src_out      = src_q;
  assign bus.mul_pending_out = cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ordering, drain, flush, rd=0, fairness, reset.
// Expected values are hand-computed per vector.
module tb_wb_arbiter;
  import brisc_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_arbiter_if #(.MUL_FIFO_DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .MUL_FIFO_DEPTH  (DEPTH),
    .WB_STARVE_LIMIT (LIMIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input string tag, input logic we,
                    input int rd, input int res, input wb_src_e src);
    check({tag, "_we"},  bus.reg_write_out, we);
    check({tag, "_rd"},  bus.rd_write_out, rd);
    check({tag, "_res"}, bus.result_out, res);
    check({tag, "_src"}, bus.wb_src_out, src);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_in     = 1'b0;
    bus.alu_valid_in = 1'b0;
    bus.alu_rd_in    = '0;
    bus.alu_res_in   = '0;
    bus.mul_valid_in = 1'b0;
    bus.mul_rd_in    = '0;
    bus.mul_res_in   = '0;
  endtask

  task automatic alu(input int rd, input int res);
    bus.alu_valid_in = 1'b1;
    bus.alu_rd_in    = REG_BITS'(rd);
    bus.alu_res_in   = XLEN'(res);
  endtask

  task automatic mul(input int rd, input int res);
    bus.mul_valid_in = 1'b1;
    bus.mul_rd_in    = REG_BITS'(rd);
    bus.mul_res_in   = XLEN'(res);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    wr("rst", 0, 0, 0, WB_SRC_NONE);
    check("rst_pend", bus.mul_pending_out, 0);
    check("rst_alu_rdy", bus.alu_ready_out, 0);
    check("rst_mul_rdy", bus.mul_ready_out, 0);
    reset_n = 1'b1;
    #1;
    check("rel_alu_rdy", bus.alu_ready_out, 1);
    check("rel_mul_rdy", bus.mul_ready_out, 1);

    // ALU and MUL together, FIFO empty
    alu(5, 'h11);
    mul(6, 'h22);
    #1;
    check("pair_rdy", bus.alu_ready_out, 1);
    step();
    idle();
    wr("pair1", 1, 5, 'h11, WB_SRC_ALU);
    check("pair1_pend", bus.mul_pending_out, 1);
    step();
    wr("pair2", 1, 6, 'h22, WB_SRC_MUL);
    check("pair2_pend", bus.mul_pending_out, 0);
    step();
    wr("nogrant", 0, 0, 0, WB_SRC_NONE);

    // MUL bypass to x0
    mul(0, 'h33);
    step();
    idle();
    wr("x0", 0, 0, 'h33, WB_SRC_MUL);

    // fill FIFO under continuous ALU, then drain
    for (int i = 0; i < 4; i++) begin
      alu(10, 'hA0 + i);
      mul(20 + i, 'h200 + i);
      #1;
      check("fill_rdy", bus.alu_ready_out, 1);
      step();
      wr("fill", 1, 10, 'hA0 + i, WB_SRC_ALU);
    end
    bus.mul_valid_in = 1'b0;
    alu(10, 'hA4);
    #1;
    check("full_pend", bus.mul_pending_out, 4);
    check("full_mul_rdy", bus.mul_ready_out, 0);
    check("full_alu_rdy", bus.alu_ready_out, 1);
    step();
    wr("full", 1, 10, 'hA4, WB_SRC_ALU);
    alu(10, 'hA5);
    for (int j = 0; j < 4; j++) begin
      check("drain_rdy", bus.alu_ready_out, 0);
      step();
      wr("drain", 1, 20 + j, 'h200 + j, WB_SRC_MUL);
    end
    check("resume_rdy", bus.alu_ready_out, 1);
    check("resume_pend", bus.mul_pending_out, 0);
    step();
    idle();
    wr("resume", 1, 10, 'hA5, WB_SRC_ALU);

    // flush with one queued MUL result
    alu(11, 'hB0);
    mul(21, 'h321);
    step();
    idle();
    wr("fl0", 1, 11, 'hB0, WB_SRC_ALU);
    check("fl0_pend", bus.mul_pending_out, 1);
    bus.flush_in = 1'b1;
    alu(7, 'h77);
    #1;
    check("fl_rdy", bus.alu_ready_out, 1);
    step();
    idle();
    wr("fl1", 1, 21, 'h321, WB_SRC_MUL);
    check("fl1_pend", bus.mul_pending_out, 0);

    // continuous ALU with one queued MUL result
    alu(12, 'hC0);
    mul(22, 'h422);
    step();
    bus.mul_valid_in = 1'b0;
    wr("st0", 1, 12, 'hC0, WB_SRC_ALU);
`ifdef WB_ARB_FAIR_EN
    for (int k = 1; k <= 8; k++) begin
      alu(12, 'hC0 + k);
      #1;
      check("st_rdy", bus.alu_ready_out, 1);
      step();
      wr("st", 1, 12, 'hC0 + k, WB_SRC_ALU);
    end
    alu(12, 'hC9);
    #1;
    check("st9_rdy", bus.alu_ready_out, 0);
    step();
    wr("st9", 1, 22, 'h422, WB_SRC_MUL);
    check("st10_rdy", bus.alu_ready_out, 1);
    step();
    idle();
    wr("st10", 1, 12, 'hC9, WB_SRC_ALU);
`else
    for (int k = 1; k <= 12; k++) begin
      alu(12, 'hC0 + k);
      #1;
      check("st_rdy", bus.alu_ready_out, 1);
      step();
      wr("st", 1, 12, 'hC0 + k, WB_SRC_ALU);
    end
    idle();
    step();
    wr("st_end", 1, 22, 'h422, WB_SRC_MUL);
`endif

    // reset while draining with 3 entries left
    for (int i = 0; i < 4; i++) begin
      alu(13, 'hD0 + i);
      mul(24 + i, 'h500 + i);
      step();
    end
    bus.mul_valid_in = 1'b0;
    alu(13, 'hD4);
    step();
    step();
    wr("rd_pop", 1, 24, 'h500, WB_SRC_MUL);
    check("rd_pend", bus.mul_pending_out, 3);
    #2;
    reset_n = 1'b0;
    #1;
    wr("rd_rst", 0, 0, 0, WB_SRC_NONE);
    check("rd_rst_pend", bus.mul_pending_out, 0);
    check("rd_rst_alu", bus.alu_ready_out, 0);
    check("rd_rst_mul", bus.mul_ready_out, 0);
    idle();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_we", bus.reg_write_out, 0);
      check("post_pend", bus.mul_pending_out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter MUL_FIFO_DEPTH, default 4: number of MUL results held while the write port is busy.
REQ-002 Parameter WB_STARVE_LIMIT, default 8: consecutive lost cycles before a forced MUL grant (see REQ-025).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 flush_in  in  1  discard the ALU request this cycle; MUL FIFO unaffected.
REQ-006 alu_valid_in / alu_rd_in / alu_res_in  in  1/REG_BITS/XLEN  ALU-side writeback request.
REQ-007 alu_ready_out  out  1  ALU request accepted this cycle; the pipeline stalls when low.
REQ-008 mul_valid_in / mul_rd_in / mul_res_in  in  1/REG_BITS/XLEN  MUL-side writeback request.
REQ-009 mul_ready_out  out  1  FIFO count < MUL_FIFO_DEPTH.
REQ-010 reg_write_out / rd_write_out / result_out  out  1/REG_BITS/XLEN  registered register-file write port.
REQ-011 wb_src_out  out  wb_src_e  source of the current write.
REQ-012 mul_pending_out  out  $clog2(MUL_FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-013 Exactly one grant per cycle among: ALU, FIFO head, MUL bypass; at most one register write per cycle.
REQ-014 Write-port outputs are registered: a grant in cycle N is visible on the outputs in cycle N+1 (latency 1).
REQ-015 With no grant, the next-cycle outputs are reg_write_out=0, wb_src_out=WB_SRC_NONE, rd_write_out=0, result_out=0.
REQ-016 A granted request with rd=0 is consumed but drives reg_write_out=0; wb_src_out still reports the source.
REQ-017 FSM states NORMAL and DRAIN; reset state NORMAL.
REQ-018 NORMAL priority order: valid ALU (not flushed), then FIFO head, then MUL bypass; bypass is allowed only when the FIFO is empty.
REQ-019 NORMAL -> DRAIN when the registered FIFO count equals MUL_FIFO_DEPTH; DRAIN -> NORMAL when the count is 0 after the current pop.
REQ-020 In DRAIN, alu_ready_out=0 and the FIFO head is granted every cycle.
REQ-021 A MUL input that is valid and not bypass-granted is pushed into the FIFO; a simultaneous push and pop leaves the count unchanged.
REQ-022 MUL results retire in arrival order; the FIFO head always precedes a newer MUL input.
REQ-023 mul_valid_in while mul_ready_out=0 is a protocol violation; the input is dropped and the count is unchanged.
REQ-024 alu_ready_out=1 in NORMAL unless the forced-MUL grant of REQ-025 is taken that cycle; flush_in forces alu_ready_out=1 and no ALU grant.

Configuration
REQ-025 With WB_ARB_FAIR_EN defined: a saturating counter counts consecutive cycles in which the FIFO is non-empty and not granted; at WB_STARVE_LIMIT the FIFO head is granted once (alu_ready_out=0 that cycle) and the counter clears.
REQ-026 Without WB_ARB_FAIR_EN: no counter, strict ALU priority in NORMAL, and REQ-025 logic is absent.

Reset
REQ-027 reset_n low asynchronously sets: FIFO empty, FSM in NORMAL, starve counter 0, reg_write_out=0, rd_write_out=0, result_out=0, wb_src_out=WB_SRC_NONE, mul_pending_out=0.
REQ-028 Reset asserted mid-drain discards all pending MUL results without producing a partial write.
REQ-029 Combinational ready outputs read 0 while reset_n is low.

Structure
REQ-030 brisc_pkg holds wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MUL}, wb_arb_state_e {NORMAL, DRAIN}, and default constants MUL_FIFO_DEPTH and WB_STARVE_LIMIT.
REQ-031 Sub-module wb_mul_fifo: circular buffer of {rd, res} with push, pop, full, empty, and count.

Verification
REQ-032 ALU valid with rd=5, res=0x11 and MUL valid with rd=6, res=0x22 in the same cycle, FIFO empty -> cycle+1 writes x5=0x11 (ALU); cycle+2 writes x6=0x22 (MUL).
REQ-033 ALU valid every cycle and 4 MUL results -> FIFO reaches 4, DRAIN is entered, alu_ready_out=0 for 4 cycles, MUL writes retire in order, then NORMAL resumes.
REQ-034 MUL valid alone with rd=0, FIFO empty -> next cycle reg_write_out=0, wb_src_out=WB_SRC_MUL.
REQ-035 flush_in with ALU valid and 1 FIFO entry -> no ALU write; the FIFO head is written the next cycle.
REQ-036 With WB_ARB_FAIR_EN: ALU continuous and 1 FIFO entry -> the MUL write occurs on cycle 9 with alu_ready_out=0 that cycle.
REQ-037 reset_n low while in DRAIN with 3 entries -> outputs zero immediately and no writes occur after release.
